inbuf_port_arbiter: RTL and testbench

// - Owns the single-port input-buffer BRAM between a frame loader (write) and the 3x3 window engine (read).
// - Sequences each frame: IDLE -> LOAD (writes DEPTH pixels) -> RUN (gates window engine enable) -> IDLE.
// - Sits between clk_enable / window engine / loader and inbuf_wrapper inside cnn_top.

---
 rtl/inbuf_port_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_inbuf_port_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/inbuf_port_arbiter.sv
// Input-buffer BRAM port arbiter: sequences IDLE -> LOAD -> RUN per frame and muxes the single BRAM port
// between the frame loader and the window engine. Optional macro ARB_RR_EN enables round-robin loader writes in RUN.
module inbuf_port_arbiter #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 17,
    parameter int WIDTH  = 24,
    parameter int HEIGHT = 7
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iEn,
    input  logic              iLdStart,
    input  logic              iLdReq,
    input  logic [ADDR_W-1:0] iLdAddr,
    input  logic [DATA_W-1:0] iLdData,
    output logic              oLdGnt,
    output logic              oWinEn,
    input  logic              iRdCs,
    input  logic [ADDR_W-1:0] iRdAddr,
    output logic [DATA_W-1:0] oRdPixel,
    output logic              oRdValid,
    input  logic              iWinValid,
    output logic              oBramEn,
    output logic              oBramWe,
    output logic [ADDR_W-1:0] oBramAddr,
    output logic [DATA_W-1:0] oBramDin,
    input  logic [DATA_W-1:0] iBramDout,
    output logic              oFrameDone,
    output logic              oBusy,
    output logic              oErr
);
    localparam int DEPTH   = WIDTH * HEIGHT;
    localparam int OUT_CNT = (WIDTH - 2) * (HEIGHT - 2);
    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_WR  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] LAST_OUT = ADDR_W'(OUT_CNT - 1);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_RUN = 2'd2} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic [ADDR_W-1:0]   out_cnt_q, out_cnt_d;
    logic                rd_valid_q, rd_valid_d;
    logic                frame_done_q, frame_done_d;
    logic                err_q, err_d;
    logic                ld_win_s;
    logic                addr_ok_s;
    logic                ld_gnt_s;
    logic                win_en_s;
    logic                bram_en_s;
    logic                bram_we_s;
    logic [ADDR_W-1:0]   bram_addr_s;
    logic [DATA_W-1:0]   bram_din_s;

`ifdef ARB_RR_EN
    // Token is registered so the loader decision never depends on iRdCs.
    logic token_q, token_d;
    localparam logic TOK_RD = 1'b0;
    localparam logic TOK_LD = 1'b1;
    assign ld_win_s = (state_q == ST_RUN) & iLdReq & (token_q == TOK_LD);
`else
    assign ld_win_s = 1'b0;
`endif

    assign addr_ok_s = (iLdAddr < DEPTH_A);

    // Next-state, port mux and counter logic.
    always_comb begin
        state_d      = state_q;
        wr_cnt_d     = wr_cnt_q;
        out_cnt_d    = out_cnt_q;
        rd_valid_d   = 1'b0;
        frame_done_d = 1'b0;
        err_d        = err_q;
        ld_gnt_s     = 1'b0;
        win_en_s     = 1'b0;
        bram_en_s    = 1'b0;
        bram_we_s    = 1'b0;
        bram_addr_s  = {ADDR_W{1'b0}};
        bram_din_s   = {DATA_W{1'b0}};
`ifdef ARB_RR_EN
        token_d      = token_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (iLdStart) begin
                    state_d   = ST_LOAD;
                    wr_cnt_d  = {ADDR_W{1'b0}};
                    out_cnt_d = {ADDR_W{1'b0}};
`ifdef ARB_RR_EN
                    token_d   = TOK_RD;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (iLdReq) begin
                    ld_gnt_s    = 1'b1;
                    bram_en_s   = addr_ok_s;
                    bram_we_s   = addr_ok_s;
                    bram_addr_s = iLdAddr;
                    bram_din_s  = iLdData;
                    err_d       = err_q | ~addr_ok_s;
                    wr_cnt_d    = wr_cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    if (wr_cnt_q == LAST_WR) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (ld_win_s) begin
                    ld_gnt_s    = 1'b1;
                    bram_en_s   = addr_ok_s;
                    bram_we_s   = addr_ok_s;
                    bram_addr_s = iLdAddr;
                    bram_din_s  = iLdData;
                    err_d       = err_q | ~addr_ok_s;
                end else begin
                    win_en_s    = iEn;
                    bram_en_s   = iRdCs & iEn;
                    bram_addr_s = iRdAddr;
                    rd_valid_d  = iRdCs & iEn;
                end
`ifdef ARB_RR_EN
                if (win_en_s) begin
                    token_d = TOK_LD;
                end else if (ld_win_s) begin
                    token_d = TOK_RD;
                end else begin
                    token_d = token_q;
                end
`endif
                if (iWinValid) begin
                    out_cnt_d = out_cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    if (out_cnt_q == LAST_OUT) begin
                        frame_done_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered-output flops.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q      <= ST_IDLE;
            wr_cnt_q     <= {ADDR_W{1'b0}};
            out_cnt_q    <= {ADDR_W{1'b0}};
            rd_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
`ifdef ARB_RR_EN
            token_q      <= TOK_RD;
`endif
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            out_cnt_q    <= out_cnt_d;
            rd_valid_q   <= rd_valid_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
`ifdef ARB_RR_EN
            token_q      <= token_d;
`endif
        end
    end

    assign oLdGnt     = ld_gnt_s;
    assign oWinEn     = win_en_s;
    assign oBramEn    = bram_en_s;
    assign oBramWe    = bram_we_s;
    assign oBramAddr  = bram_addr_s;
    assign oBramDin   = bram_din_s;
    assign oRdPixel   = iBramDout;
    assign oRdValid   = rd_valid_q;
    assign oFrameDone = frame_done_q;
    assign oErr       = err_q;
    assign oBusy      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_inbuf_port_arbiter.sv
// Directed self-checking bench for inbuf_port_arbiter with a small synchronous BRAM model.
module tb_inbuf_port_arbiter;
    logic        iClk = 1'b0;
    logic        iRst = 1'b1;
    logic        iEn = 1'b0, iLdStart = 1'b0, iLdReq = 1'b0, iRdCs = 1'b0, iWinValid = 1'b0;
    logic [16:0] iLdAddr = 17'd0, iRdAddr = 17'd0;
    logic [23:0] iLdData = 24'd0;
    logic        oLdGnt, oWinEn, oRdValid, oBramEn, oBramWe, oFrameDone, oBusy, oErr;
    logic [23:0] oRdPixel, oBramDin;
    logic [16:0] oBramAddr;
    logic [23:0] bram_dout = 24'd0;
    logic [23:0] mem [0:255];
    int checks = 0;
    int errors = 0;

    inbuf_port_arbiter dut (
        .iClk(iClk), .iRst(iRst), .iEn(iEn), .iLdStart(iLdStart), .iLdReq(iLdReq),
        .iLdAddr(iLdAddr), .iLdData(iLdData), .oLdGnt(oLdGnt), .oWinEn(oWinEn),
        .iRdCs(iRdCs), .iRdAddr(iRdAddr), .oRdPixel(oRdPixel), .oRdValid(oRdValid),
        .iWinValid(iWinValid), .oBramEn(oBramEn), .oBramWe(oBramWe), .oBramAddr(oBramAddr),
        .oBramDin(oBramDin), .iBramDout(bram_dout), .oFrameDone(oFrameDone), .oBusy(oBusy),
        .oErr(oErr)
    );

    always #5 iClk = ~iClk;

    always @(posedge iClk) begin
        if (oBramEn) begin
            if (oBramWe) mem[oBramAddr[7:0]] <= oBramDin;
            else bram_dout <= mem[oBramAddr[7:0]];
        end
    end

    task automatic tick;
        @(posedge iClk);
        #1;
    endtask

    task automatic test_reset;
        iRst = 1'b1;
        tick();
        checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", oBusy); end
        checks++; if (oLdGnt !== 1'b0 || oWinEn !== 1'b0) begin errors++; $display("FAIL reset_gnt_win got=%0b%0b exp=00", oLdGnt, oWinEn); end
        checks++; if (oBramEn !== 1'b0 || oBramWe !== 1'b0 || oBramAddr !== 17'd0 || oBramDin !== 24'd0) begin errors++; $display("FAIL reset_bram got=%0b%0b %0d %0h exp=00 0 0", oBramEn, oBramWe, oBramAddr, oBramDin); end
        checks++; if (oRdValid !== 1'b0 || oFrameDone !== 1'b0 || oErr !== 1'b0) begin errors++; $display("FAIL reset_regs got=%0b%0b%0b exp=000", oRdValid, oFrameDone, oErr); end
        iRst = 1'b0;
        tick();
    endtask

    task automatic test_load;
        iEn = 1'b1;
        iLdReq = 1'b1;
        #1;
        checks++; if (oLdGnt !== 1'b0) begin errors++; $display("FAIL idle_no_grant got=%0b exp=0", oLdGnt); end
        iLdReq = 1'b0;
        iLdStart = 1'b1;
        tick();
        iLdStart = 1'b0;
        checks++; if (oBusy !== 1'b1 || oWinEn !== 1'b0) begin errors++; $display("FAIL load_entry got=%0b%0b exp=10", oBusy, oWinEn); end
        for (int i = 0; i < 168; i++) begin
            iLdReq = 1'b1;
            iLdAddr = 17'(i);
            iLdData = 24'hA00000 | 24'(i);
            #1;
            checks++;
            if (oLdGnt !== 1'b1 || oBramEn !== 1'b1 || oBramWe !== 1'b1 || oBramAddr !== 17'(i) || oBramDin !== (24'hA00000 | 24'(i)) || oWinEn !== 1'b0) begin
                errors++; $display("FAIL load_write[%0d] got gnt=%0b en=%0b we=%0b addr=%0d din=%0h win=%0b exp 1 1 1 %0d a0%04h 0", i, oLdGnt, oBramEn, oBramWe, oBramAddr, oBramDin, oWinEn, i, i);
            end
            tick();
        end
        iLdReq = 1'b0;
        #1;
        checks++; if (oWinEn !== 1'b1 || oBusy !== 1'b1 || oLdGnt !== 1'b0) begin errors++; $display("FAIL run_entry got win=%0b busy=%0b gnt=%0b exp 1 1 0", oWinEn, oBusy, oLdGnt); end
    endtask

    task automatic test_read;
        iRdCs = 1'b1;
        iRdAddr = 17'd5;
        #1;
        checks++; if (oBramEn !== 1'b1 || oBramWe !== 1'b0 || oBramAddr !== 17'd5) begin errors++; $display("FAIL read_port got en=%0b we=%0b addr=%0d exp 1 0 5", oBramEn, oBramWe, oBramAddr); end
        checks++; if (oRdValid !== 1'b0) begin errors++; $display("FAIL read_valid_early got=%0b exp=0", oRdValid); end
        tick();
        iRdCs = 1'b0;
        checks++; if (oRdValid !== 1'b1 || oRdPixel !== 24'hA00005) begin errors++; $display("FAIL read_data got valid=%0b pix=%0h exp 1 a00005", oRdValid, oRdPixel); end
        iEn = 1'b0;
        iRdCs = 1'b1;
        iRdAddr = 17'd7;
        #1;
        checks++; if (oBramEn !== 1'b0 || oWinEn !== 1'b0) begin errors++; $display("FAIL read_no_en got en=%0b win=%0b exp 0 0", oBramEn, oWinEn); end
        tick();
        iRdCs = 1'b0;
        iEn = 1'b1;
        #1;
        checks++; if (oRdValid !== 1'b0) begin errors++; $display("FAIL read_ignored_valid got=%0b exp=0", oRdValid); end
    endtask

    task automatic test_arb;
        logic exp_gnt;
        iLdReq = 1'b1;
        iLdAddr = 17'd3;
        iLdData = 24'h123456;
        for (int k = 0; k < 6; k++) begin
            #1;
`ifdef ARB_RR_EN
            exp_gnt = (k % 2 == 0);
`else
            exp_gnt = 1'b0;
`endif
            checks++;
            if (oLdGnt !== exp_gnt || oWinEn !== ~exp_gnt) begin
                errors++; $display("FAIL arb[%0d] got gnt=%0b win=%0b exp %0b %0b", k, oLdGnt, oWinEn, exp_gnt, ~exp_gnt);
            end
            tick();
        end
        iLdReq = 1'b0;
        #1;
        checks++; if (oErr !== 1'b0) begin errors++; $display("FAIL arb_err got=%0b exp=0", oErr); end
    endtask

    task automatic test_frame(input logic exp_err);
        for (int i = 0; i < 110; i++) begin
            iWinValid = 1'b1;
            if (i == 109) begin
                #1;
                checks++; if (oFrameDone !== 1'b0 || oBusy !== 1'b1) begin errors++; $display("FAIL frame_early got done=%0b busy=%0b exp 0 1", oFrameDone, oBusy); end
            end
            tick();
        end
        iWinValid = 1'b0;
        #1;
        checks++; if (oFrameDone !== 1'b1 || oBusy !== 1'b0 || oWinEn !== 1'b0) begin errors++; $display("FAIL frame_done got done=%0b busy=%0b win=%0b exp 1 0 0", oFrameDone, oBusy, oWinEn); end
        checks++; if (oErr !== exp_err) begin errors++; $display("FAIL frame_err got=%0b exp=%0b", oErr, exp_err); end
        iWinValid = 1'b1;
        tick();
        iWinValid = 1'b0;
        checks++; if (oFrameDone !== 1'b0 || oBusy !== 1'b0) begin errors++; $display("FAIL frame_pulse got done=%0b busy=%0b exp 0 0", oFrameDone, oBusy); end
    endtask

    task automatic test_out_of_range;
        iLdStart = 1'b1;
        tick();
        iLdStart = 1'b0;
        iLdReq = 1'b1;
        iLdAddr = 17'd168;
        iLdData = 24'hBADBAD;
        #1;
        checks++; if (oLdGnt !== 1'b1 || oBramEn !== 1'b0) begin errors++; $display("FAIL oor_drop got gnt=%0b en=%0b exp 1 0", oLdGnt, oBramEn); end
        tick();
        checks++; if (oErr !== 1'b1) begin errors++; $display("FAIL oor_err got=%0b exp=1", oErr); end
        for (int j = 0; j < 167; j++) begin
            iLdAddr = 17'(j);
            iLdData = 24'hA00000 | 24'(j);
            if (j == 166) begin
                #1;
                checks++; if (oWinEn !== 1'b0 || oBusy !== 1'b1) begin errors++; $display("FAIL oor_still_load got win=%0b busy=%0b exp 0 1", oWinEn, oBusy); end
            end
            tick();
        end
        iLdReq = 1'b0;
        #1;
        checks++; if (oWinEn !== 1'b1) begin errors++; $display("FAIL oor_run got win=%0b exp=1", oWinEn); end
        test_frame(1'b1);
    endtask

    task automatic test_reset_mid;
        iLdStart = 1'b1;
        tick();
        iLdStart = 1'b0;
        iLdReq = 1'b1;
        for (int j = 0; j < 50; j++) begin
            iLdAddr = 17'(j);
            iLdData = 24'hA00000 | 24'(j);
            tick();
        end
        iRst = 1'b1;
        #1;
        checks++; if (oBusy !== 1'b0 || oLdGnt !== 1'b0 || oBramEn !== 1'b0 || oBramAddr !== 17'd0) begin errors++; $display("FAIL mid_reset_out got busy=%0b gnt=%0b en=%0b addr=%0d exp 0 0 0 0", oBusy, oLdGnt, oBramEn, oBramAddr); end
        checks++; if (oErr !== 1'b0 || oFrameDone !== 1'b0) begin errors++; $display("FAIL mid_reset_regs got err=%0b done=%0b exp 0 0", oErr, oFrameDone); end
        tick();
        iRst = 1'b0;
        iLdReq = 1'b0;
        tick();
        iLdStart = 1'b1;
        tick();
        iLdStart = 1'b0;
        iLdReq = 1'b1;
        for (int j = 0; j < 168; j++) begin
            iLdAddr = 17'(j);
            iLdData = 24'hA00000 | 24'(j);
            if (j == 167) begin
                #1;
                checks++; if (oWinEn !== 1'b0 || oBusy !== 1'b1) begin errors++; $display("FAIL restart_count got win=%0b busy=%0b exp 0 1", oWinEn, oBusy); end
            end
            tick();
        end
        iLdReq = 1'b0;
        #1;
        checks++; if (oWinEn !== 1'b1 || oFrameDone !== 1'b0) begin errors++; $display("FAIL restart_run got win=%0b done=%0b exp 1 0", oWinEn, oFrameDone); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_read();
        test_arb();
        test_frame(1'b0);
        test_out_of_range();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
